serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer.sv | 135 +++++++++++++
 tb/tb_serializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serializer.sv
// serializer
//   Frames a WIDTH-bit parallel word onto a single serial line as
//   START (low), WIDTH data bits LSB first, STOP (high), with each bit held for
//   BIT_CYCLES clocks. The line idles high.
//
// Parameters
//   WIDTH       data word width, 1..32
//   BIT_CYCLES  clocks per serial bit, 1..255
//
// Ports
//   clock  in   rising-edge clock
//   reset  in   asynchronous, active-low reset
//   clear  in   synchronous abort of any frame in progress (beats load)
//   load   in   request to send d; honoured only while ready
//   d      in   word to transmit, captured on the accepting edge
//   ready  out  high in IDLE, when a load will be accepted
//   busy   out  high while a frame is on sout
//   done   out  one-cycle pulse in the first IDLE cycle after a full frame
//   sout   out  serial line
//
// All outputs are registers; each one is updated alongside the state
// transition that implies its new value.
module serializer #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             sout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Bit-period counter counts down from BC_LAST to 0, then reloads.
  localparam logic [7:0] BC_LAST  = 8'(BIT_CYCLES - 1);
  localparam logic [5:0] BIT_LAST = 6'(WIDTH - 1);

  logic [1:0]       state;
  logic [7:0]       cnt;
  logic [5:0]       bitcnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shnext;

  // The bit to be driven next is bit 0 of the already-shifted word, so sout
  // can be registered in the same edge as the shift.
  assign shnext = shreg >> 1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      sout   <= 1'b1;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (clear) begin
      // Abort: shift register is left as is, it is reloaded on the next accept.
      state  <= IDLE;
      cnt    <= '0;
      bitcnt <= '0;
      sout   <= 1'b1;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            state  <= START;
            shreg  <= d;
            cnt    <= BC_LAST;
            bitcnt <= '0;
            sout   <= 1'b0;
            ready  <= 1'b0;
            busy   <= 1'b1;
          end
        end
        START: begin
          if (cnt == 8'd0) begin
            state <= DATA;
            cnt   <= BC_LAST;
            sout  <= shreg[0];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DATA: begin
          if (cnt == 8'd0) begin
            cnt <= BC_LAST;
            if (bitcnt == BIT_LAST) begin
              state <= STOP;
              sout  <= 1'b1;
            end else begin
              shreg  <= shnext;
              sout   <= shnext[0];
              bitcnt <= bitcnt + 6'd1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STOP: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          sout  <= 1'b1;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb_serializer
//   Directed bench for serializer at WIDTH=4, BIT_CYCLES=2 (12-cycle frames).
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_serializer;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       load;
  logic [3:0] d;
  logic       ready;
  logic       busy;
  logic       done;
  logic       sout;

  int errors = 0;
  int checks = 0;

  serializer #(.WIDTH(4), .BIT_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .load  (load),
    .d     (d),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sout  (sout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected sout at cycle k (0..11) of a frame carrying w.
  function automatic logic exp_sout(input logic [3:0] w, input int k);
    if (k < 2)  return 1'b0;
    if (k < 10) return w[(k - 2) / 2];
    return 1'b1;
  endfunction

  // Called at a falling edge with load=1 and d=w already driven; the next
  // rising edge accepts. d is scrambled after acceptance to show it is ignored.
  task automatic run_frame(input logic [3:0] w, input string tag);
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (k == 0) begin
        load = 1'b0;
        d    = ~w;
      end
      chk({tag, " sout"}, 32'(sout), 32'(exp_sout(w, k)));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " ready"}, 32'(ready), 32'd0);
    end
    @(negedge clock);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " idle sout"}, 32'(sout), 32'd1);
    chk({tag, " idle ready"}, 32'(ready), 32'd1);
    @(negedge clock);
    chk({tag, " done cleared"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    clear = 1'b0;
    load  = 1'b0;
    d     = 4'b0000;

    // Held in reset with the clock running.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst sout", 32'(sout), 32'd1);
      chk("rst ready", 32'(ready), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    @(negedge clock);
    chk("post-rst idle sout", 32'(sout), 32'd1);
    chk("post-rst idle ready", 32'(ready), 32'd1);

    // Single frame of 4'b0101: 0,0,1,1,0,0,1,1,0,0,1,1 then done.
    load = 1'b1;
    d    = 4'b0101;
    run_frame(4'b0101, "f0101");

    // Load held high, d = 1 + i/2 before rising edge i; words accepted at
    // edges 0, 13, 26 are 1, 7, 14.
    load = 1'b1;
    d    = 4'd1;
    for (int i = 0; i < 39; i++) begin
      automatic int f = i % 13;
      automatic logic [3:0] w;
      @(negedge clock);
      case (i / 13)
        0:       w = 4'd1;
        1:       w = 4'd7;
        default: w = 4'd14;
      endcase
      if (f < 12) begin
        chk("b2b sout", 32'(sout), 32'(exp_sout(w, f)));
        chk("b2b busy", 32'(busy), 32'd1);
      end else begin
        chk("b2b gap done", 32'(done), 32'd1);
        chk("b2b gap sout", 32'(sout), 32'd1);
        chk("b2b gap ready", 32'(ready), 32'd1);
      end
      d = 4'(1 + (i + 1) / 2);
      if (i == 38) load = 1'b0;
    end
    @(negedge clock);
    chk("b2b end done", 32'(done), 32'd0);
    chk("b2b end busy", 32'(busy), 32'd0);

    // Clear during the third data bit (bit2 of 1011 is 0).
    load = 1'b1;
    d    = 4'b1011;
    for (int k = 0; k < 7; k++) begin
      @(negedge clock);
      if (k == 0) load = 1'b0;
    end
    chk("clr pre sout", 32'(sout), 32'd0);
    chk("clr pre busy", 32'(busy), 32'd1);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clr sout", 32'(sout), 32'd1);
    chk("clr ready", 32'(ready), 32'd1);
    chk("clr busy", 32'(busy), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("clr no done", 32'(done), 32'd0);
      chk("clr idle sout", 32'(sout), 32'd1);
    end

    // load and clear together in IDLE: nothing starts.
    load  = 1'b1;
    clear = 1'b1;
    d     = 4'b0000;
    @(negedge clock);
    load  = 1'b0;
    clear = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("ldclr sout", 32'(sout), 32'd1);
      chk("ldclr busy", 32'(busy), 32'd0);
      chk("ldclr ready", 32'(ready), 32'd1);
      @(negedge clock);
    end

    // Reset pulsed in the first STOP cycle of a 4'b0110 frame.
    load = 1'b1;
    d    = 4'b0110;
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      if (k == 0) load = 1'b0;
    end
    chk("rstmid stop sout", 32'(sout), 32'd1);
    chk("rstmid stop busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rstmid async busy", 32'(busy), 32'd0);
    chk("rstmid async ready", 32'(ready), 32'd1);
    chk("rstmid async sout", 32'(sout), 32'd1);
    chk("rstmid async done", 32'(done), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("rstmid no done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    load  = 1'b1;
    d     = 4'b1001;
    run_frame(4'b1001, "f1001");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
